// File: rtl/microwave_cook_ctrl_if.sv
// microwave_cook_ctrl_if: front-panel/door inputs and latch/timer/beeper outputs of the cook controller
interface microwave_cook_ctrl_if;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       time_zero;
    logic       latch_s;
    logic       latch_r;
    logic       timer_en;
    logic       timer_clr;
    logic       beep;
    logic [1:0] state;
    modport master (
        output start, stop_clear, door_closed, time_zero,
        input  latch_s, latch_r, timer_en, timer_clr, beep, state
    );
    modport slave (
        input  start, stop_clear, door_closed, time_zero,
        output latch_s, latch_r, timer_en, timer_clr, beep, state
    );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// microwave_cook_ctrl: cooking-cycle FSM driving latchsr pulses, countdown timer enable/clear and end-of-cook beep
module microwave_cook_ctrl #(
    parameter int BEEP_CYCLES = 8,
    localparam int BW = $clog2(BEEP_CYCLES + 1)
) (
    input logic                   clk,
    input logic                   rst,
    microwave_cook_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam logic [BW-1:0] BEEP_INIT = BW'(BEEP_CYCLES);
    state_t        state_q;
    logic [BW-1:0] cnt_q;
    logic          start_q, stop_q;
    logic          latch_s_q, latch_r_q, timer_en_q, timer_clr_q, beep_q;
    logic          start_re_d, stop_re_d;
    assign start_re_d = bus.start & ~start_q;
    assign stop_re_d  = bus.stop_clear & ~stop_q;
    // Edge registers reset to 1 so a button held through reset release is not seen as a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
            latch_s_q   <= 1'b0;
            latch_r_q   <= 1'b0;
            timer_en_q  <= 1'b0;
            timer_clr_q <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            start_q     <= bus.start;
            stop_q      <= bus.stop_clear;
            latch_s_q   <= 1'b0;
            latch_r_q   <= 1'b0;
            timer_en_q  <= 1'b0;
            timer_clr_q <= 1'b0;
            beep_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_re_d && bus.door_closed && !bus.time_zero) begin
                        state_q    <= COOK;
                        latch_s_q  <= 1'b1;
                        timer_en_q <= 1'b1;
                    end else if (stop_re_d) begin
                        timer_clr_q <= 1'b1;
                    end
                end
                COOK: begin
                    if (bus.time_zero) begin
                        state_q   <= DONE;
                        latch_r_q <= 1'b1;
                        cnt_q     <= BEEP_INIT;
                        beep_q    <= 1'b1;
                    end else if (!bus.door_closed || stop_re_d) begin
                        state_q   <= PAUSE;
                        latch_r_q <= 1'b1;
                    end else begin
                        timer_en_q <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop_re_d) begin
                        state_q     <= IDLE;
                        timer_clr_q <= 1'b1;
                    end else if (start_re_d && bus.door_closed) begin
                        state_q    <= COOK;
                        latch_s_q  <= 1'b1;
                        timer_en_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Counter holds the beep cycles still to go including the current one
                    if (stop_re_d || !bus.door_closed || cnt_q <= BW'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q  <= cnt_q - BW'(1);
                        beep_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.latch_s   = latch_s_q;
    assign bus.latch_r   = latch_r_q;
    assign bus.timer_en  = timer_en_q;
    assign bus.timer_clr = timer_clr_q;
    assign bus.beep      = beep_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// tb_microwave_cook_ctrl: directed and randomized checks of the cook controller against a behavioural model
module tb_microwave_cook_ctrl;
    localparam int BEEP = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    microwave_cook_ctrl_if bus ();
    microwave_cook_ctrl #(.BEEP_CYCLES(BEEP)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 cooking, 2 paused, 3 beeping
    int   m_mode, m_beep_left;
    logic m_prev_start, m_prev_stop;
    logic e_ls, e_lr, e_clr;

    function automatic logic [6:0] obs();
        return {bus.state, bus.latch_s, bus.latch_r, bus.timer_en, bus.timer_clr, bus.beep};
    endfunction

    function automatic logic [6:0] model_vec();
        return {2'(m_mode), e_ls, e_lr, m_mode == 1, e_clr, m_mode == 3 && m_beep_left > 0};
    endfunction

    task automatic m_reset();
        m_mode = 0; m_beep_left = 0; m_prev_start = 1'b1; m_prev_stop = 1'b1;
        e_ls = 1'b0; e_lr = 1'b0; e_clr = 1'b0;
    endtask

    task automatic m_step(input logic s, input logic p, input logic d, input logic z);
        logic pressed_start, pressed_stop;
        pressed_start = s && !m_prev_start;
        pressed_stop  = p && !m_prev_stop;
        m_prev_start = s; m_prev_stop = p;
        e_ls = 1'b0; e_lr = 1'b0; e_clr = 1'b0;
        if (m_mode == 0) begin
            if (pressed_start && d && !z) begin m_mode = 1; e_ls = 1'b1; end
            else if (pressed_stop) e_clr = 1'b1;
        end else if (m_mode == 1) begin
            if (z) begin m_mode = 3; e_lr = 1'b1; m_beep_left = BEEP; end
            else if (!d || pressed_stop) begin m_mode = 2; e_lr = 1'b1; end
        end else if (m_mode == 2) begin
            if (pressed_stop) begin m_mode = 0; e_clr = 1'b1; end
            else if (pressed_start && d) begin m_mode = 1; e_ls = 1'b1; end
        end else begin
            m_beep_left = (pressed_stop || !d) ? 0 : m_beep_left - 1;
            if (m_beep_left == 0) m_mode = 0;
        end
    endtask

    task automatic tick(input logic s, input logic p, input logic d, input logic z);
        bus.start = s; bus.stop_clear = p; bus.door_closed = d; bus.time_zero = z;
        @(posedge clk);
        m_step(s, p, d, z);
        #1;
    endtask

    task automatic go_cook();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.stop_clear = 1'b1; bus.door_closed = 1'b1; bus.time_zero = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL reset_vals: got %b want %b", obs(), 7'b0000000); end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL reset_held_start: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_cook_start();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0110100) begin n_fail++; $display("FAIL cook_enter: got %b want %b", obs(), 7'b0110100); end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0100100) begin n_fail++; $display("FAIL cook_hold: got %b want %b", obs(), 7'b0100100); end
    endtask

    task automatic test_pause_resume();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs() !== 7'b1001000) begin n_fail++; $display("FAIL pause_enter: got %b want %b", obs(), 7'b1001000); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs() !== 7'b1000000) begin n_fail++; $display("FAIL pause_door_open_start: got %b want %b", obs(), 7'b1000000); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0110100) begin n_fail++; $display("FAIL resume: got %b want %b", obs(), 7'b0110100); end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0100100) begin n_fail++; $display("FAIL resume_pulse_end: got %b want %b", obs(), 7'b0100100); end
    endtask

    task automatic test_done_beep();
        int beeps;
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== 7'b1101001) begin n_fail++; $display("FAIL done_enter: got %b want %b", obs(), 7'b1101001); end
        beeps = int'(bus.beep);
        for (int i = 0; i < 4 * BEEP && bus.state == 2'd3; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            beeps += int'(bus.beep);
        end
        n_cmp++;
        if (beeps != BEEP) begin n_fail++; $display("FAIL beep_len: got %0d want %0d", beeps, BEEP); end
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL done_to_idle: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_done_priority();
        go_cook();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs() !== 7'b1101001) begin n_fail++; $display("FAIL done_over_door: got %b want %b", obs(), 7'b1101001); end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== 7'b1100001) begin n_fail++; $display("FAIL single_latch_r: got %b want %b", obs(), 7'b1100001); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL done_door_abort: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_stop_priority();
        go_cook();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b1000000) begin n_fail++; $display("FAIL pause_closed: got %b want %b", obs(), 7'b1000000); end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000010) begin n_fail++; $display("FAIL stop_over_start: got %b want %b", obs(), 7'b0000010); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL clr_pulse_end: got %b want %b", obs(), 7'b0000000); end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000010) begin n_fail++; $display("FAIL idle_clear: got %b want %b", obs(), 7'b0000010); end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL idle_clear_held: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_done_abort();
        go_cook();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== 7'b1100001) begin n_fail++; $display("FAIL third_beep: got %b want %b", obs(), 7'b1100001); end
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL done_stop_abort: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_async_reset();
        go_cook();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        m_reset();
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs(), 7'b0000000); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL reset_no_latch_r: got %b want %b", obs(), 7'b0000000); end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs() !== 7'b0000000) begin n_fail++; $display("FAIL post_reset_held: got %b want %b", obs(), 7'b0000000); end
    endtask

    task automatic test_random();
        logic s, p, d, z;
        for (int i = 0; i < 400; i++) begin
            s = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 9) != 0);
            z = ($urandom_range(0, 11) == 0);
            tick(s, p, d, z);
            n_cmp++;
            if (obs() !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b want %b", i, obs(), model_vec());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_cook_start();
        test_pause_resume();
        test_done_beep();
        test_done_priority();
        test_stop_priority();
        test_done_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
Cooking-cycle controller for the microwave. It sequences the magnetron SR latch (latchsr) through one-cycle set/reset pulses and enables and clears the countdown timer. It also generates the end-of-cook beep. It sits in the Control level between the front-panel inputs and door sensor on one side, and latchsr plus the countdown timer on the other.

Parameters:
BEEP_CYCLES, 8, number of clk cycles beep stays high in DONE (>=1)
BW, $clog2(BEEP_CYCLES+1), width of internal beep counter (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  start button level, synchronous to clk; rising edge detected internally
stop_clear  input  1  stop/clear button level; rising edge detected internally
door_closed  input  1  1 = door closed
time_zero  input  1  countdown timer reads zero
latch_s  output  1  one-cycle set pulse to latchsr s
latch_r  output  1  one-cycle reset pulse to latchsr r
timer_en  output  1  countdown enable, high exactly while in COOK
timer_clr  output  1  one-cycle clear pulse to countdown timer
beep  output  1  buzzer drive
state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3

Behaviour:
- Reset (async, rst=1): state=IDLE, beep counter=0, all outputs 0. start_d and stop_d edge registers are forced to 1, so a button held through reset release does not produce an edge.
- Edges: start_re = start & ~start_d; stop_re = stop_clear & ~stop_d. start_d and stop_d update every clk.
- Timing: inputs are sampled at rising edge k. State and all outputs are registered from next-state logic at edge k and are visible in cycle k+1.
- Pulses: latch_s, latch_r and timer_clr are high for exactly one cycle, only on the transitions listed below. latch_s and latch_r are never high in the same cycle.
- IDLE:
  - start_re & door_closed & ~time_zero -> COOK, latch_s=1.
  - stop_re -> stay IDLE, timer_clr=1.
  - Otherwise hold.
  - start_re with the door open or with time_zero=1 is ignored.
- COOK (timer_en=1), checked in priority order:
  1. time_zero -> DONE, latch_r=1, beep counter loaded with BEEP_CYCLES.
  2. ~door_closed | stop_re -> PAUSE, latch_r=1.
  3. Otherwise hold. start_re is ignored.
- PAUSE (timer_en=0, timer value preserved):
  - stop_re -> IDLE, timer_clr=1. This takes priority over start_re.
  - start_re & door_closed -> COOK, latch_s=1.
  - start_re with the door open is ignored.
- DONE:
  - beep=1 while the counter is nonzero; the counter decrements each cycle. When it reaches 0 -> IDLE, and beep is 0 in the first IDLE cycle.
  - stop_re or ~door_closed ends the beep early: -> IDLE, beep=0, counter=0.
  - start_re is ignored.
- Beep length: with no interruption, beep is high for exactly BEEP_CYCLES cycles.
- Reset mid-COOK: state forced to IDLE and latch_r is NOT pulsed. The system-level rst also clears latchsr and the timer; this is a top-level requirement.
- Illegal state encodings cannot occur. The default branch returns to IDLE.

Test Plan:
1. Reset with start held high, then release rst -> state=0, no latch_s, all outputs 0. Release start and press again with door_closed=1, time_zero=0 -> state=1 one cycle after the edge, latch_s high exactly 1 cycle, timer_en=1.
2. In COOK, drop door_closed for 1 cycle -> state=2, latch_r 1 cycle, timer_en=0. Then press start with the door open -> state stays 2. Close the door and press start -> state=1, latch_s 1 cycle.
3. In COOK, assert time_zero -> state=3, latch_r 1 cycle, beep high for exactly 8 cycles (default), then state=0.
4. In COOK, assert time_zero and open the door in the same cycle -> DONE wins: state=3, single latch_r pulse, beep starts.
5. In PAUSE, press start and stop_clear on the same edge -> state=0, timer_clr 1 cycle, latch_s stays 0. In IDLE, press stop_clear -> timer_clr 1 cycle, state stays 0.
6. In DONE after 3 beep cycles, press stop_clear -> beep=0 and state=0 on the next cycle. Separately, assert rst asynchronously mid-COOK -> state=0 and timer_en=0 immediately, latch_r stays 0.
